// File: rtl/ram_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the two-core RAM arbiter.
// The slave modport is the arbiter's view; master is the system/bench side.
interface ram_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0] req_ren;
  logic [NREQ-1:0] req_wen;
  logic [NREQ-1:0] req_lock;
  logic [31:0]     req_addr0;
  logic [31:0]     req_addr1;
  logic [31:0]     req_store0;
  logic [31:0]     req_store1;
  logic [NREQ-1:0] req_wait;
  logic [NREQ-1:0] req_err;
  logic [31:0]     req_load;
  logic [NREQ-1:0] grant;
  logic            memREN;
  logic            memWEN;
  logic [31:0]     memaddr;
  logic [31:0]     memstore;
  logic [31:0]     ramload;
  logic [1:0]      ramstate;

  modport slave (
    input  req_ren, req_wen, req_lock, req_addr0, req_addr1, req_store0, req_store1,
    input  ramload, ramstate,
    output req_wait, req_err, req_load, grant, memREN, memWEN, memaddr, memstore
  );

  modport master (
    output req_ren, req_wen, req_lock, req_addr0, req_addr1, req_store0, req_store1,
    output ramload, ramstate,
    input  req_wait, req_err, req_load, grant, memREN, memWEN, memaddr, memstore
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between two cache requesters, with
// completion/error handling, a per-grant timeout and optional locked bursts.
module ram_arbiter #(
  parameter int NREQ      = 2,
  parameter int TIMEOUT   = 64,
  parameter int MAX_BURST = 4
) (
  input logic          CLK,
  input logic          RST,
  ram_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t          state_r, state_s;
  logic            owner_r, owner_s;
  logic            last_r, last_s;
  logic [7:0]      tmo_cnt_r, tmo_cnt_s;
  logic [3:0]      burst_cnt_r, burst_cnt_s;
  logic [NREQ-1:0] grant_r, grant_s;
  logic [NREQ-1:0] active_s;
  logic [NREQ-1:0] wait_s;
  logic [NREQ-1:0] err_s;
  logic            own_ren_s, own_wen_s, own_lock_s;
  logic [31:0]     own_addr_s, own_store_s;
  logic            mem_ren_s, mem_wen_s;
  logic [31:0]     mem_addr_s, mem_store_s;

  assign active_s    = bus.req_ren | bus.req_wen;
  assign own_ren_s   = bus.req_ren[owner_r];
  assign own_wen_s   = bus.req_wen[owner_r];
  assign own_lock_s  = bus.req_lock[owner_r];
  assign own_addr_s  = owner_r ? bus.req_addr1 : bus.req_addr0;
  assign own_store_s = owner_r ? bus.req_store1 : bus.req_store0;

  // Next-state, arbitration decision and combinational RAM/requester outputs
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    last_s      = last_r;
    tmo_cnt_s   = tmo_cnt_r;
    burst_cnt_s = burst_cnt_r;
    grant_s     = grant_r;
    wait_s      = {NREQ{1'b1}};
    err_s       = {NREQ{1'b0}};
    mem_ren_s   = 1'b0;
    mem_wen_s   = 1'b0;
    mem_addr_s  = 32'h0000_0000;
    mem_store_s = 32'h0000_0000;

    case (state_r)
      IDLE: begin
        tmo_cnt_s   = 8'd0;
        burst_cnt_s = 4'd0;
        grant_s     = {NREQ{1'b0}};
        if (active_s != 2'b00) begin
          // Contention goes to whoever did not finish last
          if (active_s == 2'b11) begin
            owner_s = ~last_r;
          end else begin
            owner_s = active_s[1];
          end
          state_s = OWN;
          grant_s = owner_s ? 2'b10 : 2'b01;
        end else begin
          state_s = IDLE;
        end
      end

      OWN: begin
        mem_addr_s  = own_addr_s;
        mem_store_s = own_store_s;
        mem_wen_s   = own_wen_s;
        mem_ren_s   = own_ren_s & ~own_wen_s;
        tmo_cnt_s   = (tmo_cnt_r == 8'hFF) ? tmo_cnt_r : tmo_cnt_r + 8'd1;
        if (!(own_ren_s | own_wen_s)) begin
          state_s     = IDLE;
          grant_s     = {NREQ{1'b0}};
          burst_cnt_s = 4'd0;
        end else if (bus.ramstate == RAM_ACCESS) begin
          wait_s[owner_r] = 1'b0;
          tmo_cnt_s       = 8'd0;
          if (own_lock_s && (burst_cnt_r < BURST_LAST)) begin
            burst_cnt_s = burst_cnt_r + 4'd1;
            state_s     = OWN;
          end else begin
            last_s      = owner_r;
            burst_cnt_s = 4'd0;
            state_s     = IDLE;
            grant_s     = {NREQ{1'b0}};
          end
        end else if (bus.ramstate == RAM_ERROR) begin
          wait_s[owner_r] = 1'b0;
          err_s[owner_r]  = 1'b1;
          last_s          = owner_r;
          burst_cnt_s     = 4'd0;
          state_s         = IDLE;
          grant_s         = {NREQ{1'b0}};
        end else if (tmo_cnt_r == TMO_LAST) begin
          // Abort: release the RAM strobes in the same cycle the error is flagged
          wait_s[owner_r] = 1'b0;
          err_s[owner_r]  = 1'b1;
          mem_ren_s       = 1'b0;
          mem_wen_s       = 1'b0;
          last_s          = owner_r;
          burst_cnt_s     = 4'd0;
          state_s         = IDLE;
          grant_s         = {NREQ{1'b0}};
        end else begin
          state_s = OWN;
        end
      end

      default: begin
        state_s     = IDLE;
        grant_s     = {NREQ{1'b0}};
        tmo_cnt_s   = 8'd0;
        burst_cnt_s = 4'd0;
      end
    endcase
  end

  // State, arbitration history and counters; RST drops any in-flight transaction
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      tmo_cnt_r   <= 8'd0;
      burst_cnt_r <= 4'd0;
      grant_r     <= {NREQ{1'b0}};
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      last_r      <= last_s;
      tmo_cnt_r   <= tmo_cnt_s;
      burst_cnt_r <= burst_cnt_s;
      grant_r     <= grant_s;
    end
  end

  assign bus.req_wait = wait_s;
  assign bus.req_err  = err_s;
  assign bus.req_load = bus.ramload;
  assign bus.grant    = grant_r;
  assign bus.memREN   = mem_ren_s;
  assign bus.memWEN   = mem_wen_s;
  assign bus.memaddr  = mem_addr_s;
  assign bus.memstore = mem_store_s;

endmodule
